// File: rtl/gen_pkg.sv
// Types shared between the turn scheduler and the player logic:
// FSM state encoding, player id type and the neutral player id.
package gen_pkg;

  localparam int GEN_MAX_PLAYER_CNT      = 7;
  localparam int GEN_LOG2_MAX_PLAYER_CNT = $clog2(GEN_MAX_PLAYER_CNT + 1);

  typedef logic [GEN_LOG2_MAX_PLAYER_CNT-1:0] player_t;

  localparam player_t PLAYER_NONE = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OVER = 2'd2
  } state_t;

endpackage

// File: rtl/turn_scheduler_if.sv
// Bus between the game-state datapath (master) and the turn scheduler (slave).
interface turn_scheduler_if #(
  parameter int MAX_PLAYER_CNT      = 7,
  parameter int LOG2_MAX_PLAYER_CNT = $clog2(MAX_PLAYER_CNT + 1),
  parameter int LOG2_MAX_ROUND      = 12,
  parameter int TURN_SECONDS        = 10,
  parameter int LOG2_TURN_SECONDS   = $clog2(TURN_SECONDS + 1)
);

  logic                           start;
  logic [MAX_PLAYER_CNT-1:0]      alive_mask;
  logic                           end_turn;
  logic [LOG2_MAX_PLAYER_CNT-1:0] current_player;
  logic [LOG2_MAX_PLAYER_CNT-1:0] next_player;
  logic                           turn_start;
  logic [LOG2_TURN_SECONDS-1:0]   time_left;
  logic [LOG2_MAX_ROUND-1:0]      round;
  logic                           game_over;
  logic [LOG2_MAX_PLAYER_CNT-1:0] winner;

  modport master (
    output start, alive_mask, end_turn,
    input  current_player, next_player, turn_start, time_left, round, game_over, winner
  );

  modport slave (
    input  start, alive_mask, end_turn,
    output current_player, next_player, turn_start, time_left, round, game_over, winner
  );

endinterface

// File: rtl/turn_scheduler_sec_prescaler.sv
// Free-running seconds prescaler: emits a one-cycle tick every TICKS_PER_SEC
// enabled cycles; clear restarts the count from zero.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencer: rotates the turn among alive players, runs the per-turn
// countdown, counts rounds and detects game end by elimination or round limit.
module turn_scheduler #(
  parameter int MAX_PLAYER_CNT      = 7,
  parameter int LOG2_MAX_PLAYER_CNT = $clog2(MAX_PLAYER_CNT + 1),
  parameter int LOG2_MAX_ROUND      = 12,
  parameter int TICKS_PER_SEC       = 100_000_000,
  parameter int TURN_SECONDS        = 10,
  parameter int LOG2_TURN_SECONDS   = $clog2(TURN_SECONDS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  turn_scheduler_if.slave  bus
);

  import gen_pkg::*;

  typedef logic [LOG2_MAX_PLAYER_CNT-1:0] pid_t;
  typedef logic [LOG2_TURN_SECONDS-1:0]   secs_t;
  typedef logic [LOG2_MAX_ROUND-1:0]      round_t;

  localparam pid_t   NONE_ID   = pid_t'(PLAYER_NONE);
  localparam secs_t  TIME_FULL = secs_t'(TURN_SECONDS);
  localparam secs_t  TIME_ONE  = secs_t'(1);
  localparam round_t ROUND_ONE = round_t'(1);
  localparam round_t ROUND_MAX = '1;

  // First alive id scanning from+1..MAX, then 1..from; from=0 yields the lowest alive id.
  function automatic pid_t first_after(input logic [MAX_PLAYER_CNT:0] mask_ext, input pid_t from);
    pid_t id;
    int   cand;
    id = NONE_ID;
    for (int i = MAX_PLAYER_CNT; i >= 1; i--) begin
      cand = ((int'(from) + i - 1) % MAX_PLAYER_CNT) + 1;
      if (mask_ext[pid_t'(cand)]) id = pid_t'(cand);
    end
    return id;
  endfunction

  state_t state_q, state_d;
  pid_t   cur_q, cur_d, winner_q, winner_d;
  secs_t  time_q, time_d;
  round_t round_q, round_d;
  logic   turn_start_q, turn_start_d;

  logic [MAX_PLAYER_CNT:0] alive_ext;
  pid_t scan_next, first_alive;
  logic few_alive, cur_alive, timeout, switch_req, wrap, round_limit;
  logic sec_tick, presc_clear, presc_enable;

  // Bit 0 is a dummy slot so a player id indexes its own alive bit directly.
  assign alive_ext    = {bus.alive_mask, 1'b0};
  assign few_alive    = $countones(bus.alive_mask) <= 1;
  assign cur_alive    = alive_ext[cur_q];
  assign scan_next    = first_after(alive_ext, cur_q);
  assign first_alive  = first_after(alive_ext, NONE_ID);
  assign timeout      = sec_tick && (time_q == TIME_ONE);
  assign switch_req   = (state_q == TURN) && !few_alive && (!cur_alive || bus.end_turn || timeout);
  assign wrap         = scan_next <= cur_q;
  assign round_limit  = round_q == ROUND_MAX;
  assign presc_enable = state_q == TURN;

  sec_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (presc_clear),
    .enable (presc_enable),
    .tick   (sec_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_q        <= NONE_ID;
      winner_q     <= NONE_ID;
      time_q       <= '0;
      round_q      <= '0;
      turn_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      winner_q     <= winner_d;
      time_q       <= time_d;
      round_q      <= round_d;
      turn_start_q <= turn_start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = few_alive ? OVER : TURN;
      TURN:    if (few_alive || (switch_req && wrap && round_limit)) state_d = OVER;
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_d        = cur_q;
    winner_d     = winner_q;
    time_d       = time_q;
    round_d      = round_q;
    turn_start_d = 1'b0;
    presc_clear  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (few_alive) begin
            winner_d = first_alive;
          end else begin
            cur_d        = first_alive;
            time_d       = TIME_FULL;
            round_d      = ROUND_ONE;
            turn_start_d = 1'b1;
            presc_clear  = 1'b1;
          end
        end
      end
      TURN: begin
        if (few_alive) begin
          winner_d = first_alive;
        end else if (switch_req) begin
          // A wrap out of the last representable round ends the game as a draw.
          if (wrap && round_limit) begin
            winner_d = NONE_ID;
          end else begin
            cur_d        = scan_next;
            time_d       = TIME_FULL;
            turn_start_d = 1'b1;
            presc_clear  = 1'b1;
            if (wrap) round_d = round_q + ROUND_ONE;
          end
        end else if (sec_tick) begin
          time_d = time_q - TIME_ONE;
        end
      end
      default: ;
    endcase
  end

  assign bus.current_player = cur_q;
  assign bus.next_player    = (state_q == TURN) ? scan_next : NONE_ID;
  assign bus.turn_start     = turn_start_q;
  assign bus.time_left      = time_q;
  assign bus.round          = round_q;
  assign bus.game_over      = state_q == OVER;
  assign bus.winner         = winner_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler: turn rotation, timeouts, skips,
// elimination, round wrap and round-limit end, with hand-computed expectations.
module tb_turn_scheduler;

  localparam int MAXP = 7;
  localparam int TPS  = 4;
  localparam int TS   = 3;

  logic clock = 1'b0;
  logic reset;
  logic reset2;

  always #5 clock = ~clock;

  turn_scheduler_if #(.MAX_PLAYER_CNT(MAXP), .LOG2_MAX_ROUND(12), .TURN_SECONDS(TS)) ifc ();
  turn_scheduler_if #(.MAX_PLAYER_CNT(MAXP), .LOG2_MAX_ROUND(2),  .TURN_SECONDS(TS)) ifc2 ();

  turn_scheduler #(
    .MAX_PLAYER_CNT (MAXP),
    .LOG2_MAX_ROUND (12),
    .TICKS_PER_SEC  (TPS),
    .TURN_SECONDS   (TS)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  turn_scheduler #(
    .MAX_PLAYER_CNT (MAXP),
    .LOG2_MAX_ROUND (2),
    .TICKS_PER_SEC  (TPS),
    .TURN_SECONDS   (TS)
  ) u_dut_r2 (
    .clock (clock),
    .reset (reset2),
    .bus   (ifc2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_reset_state(input string tag);
    check({tag, ".cur"},   32'(ifc.current_player), 0);
    check({tag, ".next"},  32'(ifc.next_player),    0);
    check({tag, ".ts"},    32'(ifc.turn_start),     0);
    check({tag, ".tl"},    32'(ifc.time_left),      0);
    check({tag, ".round"}, 32'(ifc.round),          0);
    check({tag, ".go"},    32'(ifc.game_over),      0);
    check({tag, ".win"},   32'(ifc.winner),         0);
  endtask

  task automatic expect_turn(input string tag, input int cur, input int nxt, input int ts,
                             input int tl, input int rnd);
    check({tag, ".cur"},   32'(ifc.current_player), 32'(cur));
    check({tag, ".next"},  32'(ifc.next_player),    32'(nxt));
    check({tag, ".ts"},    32'(ifc.turn_start),     32'(ts));
    check({tag, ".tl"},    32'(ifc.time_left),      32'(tl));
    check({tag, ".round"}, 32'(ifc.round),          32'(rnd));
    check({tag, ".go"},    32'(ifc.game_over),      0);
  endtask

  task automatic pulse_end_turn();
    ifc.end_turn = 1'b1;
    step();
    ifc.end_turn = 1'b0;
  endtask

  task automatic pulse_start();
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
  endtask

  // Expected (current, round) after each end_turn in the 2-bit-round instance.
  int exp_r2_cur [5] = '{2, 1, 2, 1, 2};
  int exp_r2_rnd [5] = '{1, 2, 2, 3, 3};

  initial begin
    reset           = 1'b1;
    reset2          = 1'b1;
    ifc.start       = 1'b0;
    ifc.end_turn    = 1'b0;
    ifc.alive_mask  = 7'b0000111;
    ifc2.start      = 1'b0;
    ifc2.end_turn   = 1'b0;
    ifc2.alive_mask = 7'b0000000;
    step(2);
    expect_reset_state("rst");
    reset  = 1'b0;
    reset2 = 1'b0;

    pulse_end_turn();
    check("idle_endturn.cur", 32'(ifc.current_player), 0);
    check("idle_endturn.go",  32'(ifc.game_over),      0);

    // Three players, pure timeouts.
    pulse_start();
    expect_turn("t1_start", 1, 2, 1, 3, 1);
    step(3);
    check("t1_pre_tick.tl", 32'(ifc.time_left),  3);
    check("t1_pre_tick.ts", 32'(ifc.turn_start), 0);
    step();
    check("t1_dec1.tl", 32'(ifc.time_left), 2);
    step(4);
    check("t1_dec2.tl", 32'(ifc.time_left), 1);
    step(3);
    check("t1_last.cur", 32'(ifc.current_player), 1);
    check("t1_last.tl",  32'(ifc.time_left),      1);
    step();
    expect_turn("t1_timeout", 2, 3, 1, 3, 1);

    // end_turn mid-turn, then prescaler restart.
    step(4);
    check("t2_tl2.tl", 32'(ifc.time_left), 2);
    pulse_end_turn();
    expect_turn("t2_end", 3, 1, 1, 3, 1);
    step(3);
    check("t2_hold.tl", 32'(ifc.time_left), 3);
    step();
    check("t2_dec.tl", 32'(ifc.time_left), 2);
    step(8);
    expect_turn("t1_wrap", 1, 2, 1, 3, 2);

    // end_turn coincident with the final tick.
    step(11);
    check("t5_pre.cur", 32'(ifc.current_player), 1);
    check("t5_pre.tl",  32'(ifc.time_left),      1);
    pulse_end_turn();
    expect_turn("t5_once", 2, 3, 1, 3, 2);
    step();
    check("t5_single.cur", 32'(ifc.current_player), 2);
    check("t5_single.ts",  32'(ifc.turn_start),     0);

    // Reset in the middle of a turn.
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_reset_state("t5_reset");

    // Current player eliminated while others remain.
    pulse_start();
    expect_turn("dead_start", 1, 2, 1, 3, 1);
    ifc.alive_mask = 7'b0000110;
    step();
    expect_turn("dead_skip", 2, 3, 1, 3, 1);

    reset = 1'b1;
    step();
    reset = 1'b0;

    // Gap in the alive mask, then elimination down to one player.
    ifc.alive_mask = 7'b0000101;
    pulse_start();
    expect_turn("t3_start", 1, 3, 1, 3, 1);
    pulse_end_turn();
    expect_turn("t3_skip", 3, 1, 1, 3, 1);
    pulse_end_turn();
    expect_turn("t3_wrap", 1, 3, 1, 3, 2);
    pulse_end_turn();
    expect_turn("t3_again", 3, 1, 1, 3, 2);
    ifc.alive_mask = 7'b0000001;
    step();
    check("t4_over.go",    32'(ifc.game_over),      1);
    check("t4_over.win",   32'(ifc.winner),         1);
    check("t4_over.cur",   32'(ifc.current_player), 3);
    check("t4_over.next",  32'(ifc.next_player),    0);
    check("t4_over.ts",    32'(ifc.turn_start),     0);
    check("t4_over.tl",    32'(ifc.time_left),      3);
    check("t4_over.round", 32'(ifc.round),          2);
    ifc.start      = 1'b1;
    ifc.end_turn   = 1'b1;
    ifc.alive_mask = 7'b0000111;
    step(3);
    ifc.start    = 1'b0;
    ifc.end_turn = 1'b0;
    check("t4_hold.go",    32'(ifc.game_over),      1);
    check("t4_hold.win",   32'(ifc.winner),         1);
    check("t4_hold.cur",   32'(ifc.current_player), 3);
    check("t4_hold.round", 32'(ifc.round),          2);
    check("t4_hold.tl",    32'(ifc.time_left),      3);

    // Start with a single survivor or nobody alive.
    reset = 1'b1;
    step();
    reset = 1'b0;
    ifc.alive_mask = 7'b0100000;
    pulse_start();
    check("solo.go",    32'(ifc.game_over),      1);
    check("solo.win",   32'(ifc.winner),         6);
    check("solo.cur",   32'(ifc.current_player), 0);
    check("solo.round", 32'(ifc.round),          0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    ifc.alive_mask = 7'b0000000;
    pulse_start();
    check("none.go",  32'(ifc.game_over), 1);
    check("none.win", 32'(ifc.winner),    0);

    // Round limit with a 2-bit round counter.
    ifc2.alive_mask = 7'b0000011;
    ifc2.start = 1'b1;
    step();
    ifc2.start = 1'b0;
    check("r2_start.cur",   32'(ifc2.current_player), 1);
    check("r2_start.round", 32'(ifc2.round),          1);
    for (int i = 0; i < 5; i++) begin
      ifc2.end_turn = 1'b1;
      step();
      ifc2.end_turn = 1'b0;
      check($sformatf("r2_seq%0d.cur", i),   32'(ifc2.current_player), 32'(exp_r2_cur[i]));
      check($sformatf("r2_seq%0d.round", i), 32'(ifc2.round),          32'(exp_r2_rnd[i]));
      check($sformatf("r2_seq%0d.go", i),    32'(ifc2.game_over),      0);
    end
    ifc2.end_turn = 1'b1;
    step();
    ifc2.end_turn = 1'b0;
    check("r2_limit.go",    32'(ifc2.game_over),      1);
    check("r2_limit.win",   32'(ifc2.winner),         0);
    check("r2_limit.round", 32'(ifc2.round),          3);
    check("r2_limit.cur",   32'(ifc2.current_player), 2);
    check("r2_limit.ts",    32'(ifc2.turn_start),     0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
